// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter_pkg : FSM state encoding and arbitration-mode values  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_RD   = 3'd1,
    ARB_MRG  = 3'd2,
    ARB_WR   = 3'd3,
    ARB_DONE = 3'd4
  } arb_state_t;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_rr_arbiter : 2-way grant, fixed (A first) or round-robin      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_rr_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic mode,
  input  logic ptr,
  output logic gnt_a,
  output logic gnt_b,
  output logic ptr_nxt
);

  // ptr = 1 means B is favoured on the next conflict
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    ptr_nxt = ptr;
    if (req_a && req_b) begin
      if (mode && ptr) gnt_b = 1'b1;
      else             gnt_a = 1'b1;
    end else if (req_a) begin
      gnt_a = 1'b1;
    end else if (req_b) begin
      gnt_b = 1'b1;
    end
    if (gnt_a)      ptr_nxt = 1'b1;
    else if (gnt_b) ptr_nxt = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter : two-port data-memory arbiter with byte-store RMW    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [3:0]    a_be,
  input  logic [31:0]   a_wdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [3:0]    b_be,
  input  logic [31:0]   b_wdata,
  output logic          b_ack,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam logic c_RR = (ARB_MODE == ARB_MODE_RR);

  arb_state_t    r_state;
  logic          r_id;
  logic          r_ptr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_ptr_nxt;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_merged;

  dmem_rr_arbiter u_arb (
    .req_a   (a_req),
    .req_b   (b_req),
    .mode    (c_RR),
    .ptr     (r_ptr),
    .gnt_a   (w_gnt_a),
    .gnt_b   (w_gnt_b),
    .ptr_nxt (w_ptr_nxt)
  );

  assign w_we    = w_gnt_b ? b_we    : a_we;
  assign w_addr  = w_gnt_b ? b_addr  : a_addr;
  assign w_be    = w_gnt_b ? b_be    : a_be;
  assign w_wdata = w_gnt_b ? b_wdata : a_wdata;

  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : m_rdata[8*i +: 8];
  end

  // m_addr is loaded at grant so the combinational memory read is ready in RD/MRG
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_id    <= 1'b0;
      r_ptr   <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      rdata   <= 32'h0;
      busy    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= 32'h0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_a || w_gnt_b) begin
            r_id    <= w_gnt_b;
            r_ptr   <= w_ptr_nxt;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            busy    <= 1'b1;
            if (!w_we) begin
              m_addr  <= w_addr;
              r_state <= ARB_RD;
            end else if (w_be == 4'hF) begin
              m_addr  <= w_addr;
              m_wdata <= w_wdata;
              m_we    <= 1'b1;
              r_state <= ARB_WR;
            end else if (w_be != 4'h0) begin
              m_addr  <= w_addr;
              r_state <= ARB_MRG;
            end else begin
              a_ack   <= ~w_gnt_b;
              b_ack   <= w_gnt_b;
              r_state <= ARB_DONE;
            end
          end
        end
        ARB_RD: begin
          rdata   <= m_rdata;
          a_ack   <= ~r_id;
          b_ack   <= r_id;
          r_state <= ARB_DONE;
        end
        ARB_MRG: begin
          m_wdata <= w_merged;
          m_we    <= 1'b1;
          r_state <= ARB_WR;
        end
        ARB_WR: begin
          m_we    <= 1'b0;
          a_ack   <= ~r_id;
          b_ack   <= r_id;
          r_state <= ARB_DONE;
        end
        ARB_DONE: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: begin
          m_we    <= 1'b0;
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_dmem_arbiter : fixed-priority and round-robin instances vs model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // index [inst][port]: inst 0 = fixed priority, inst 1 = round robin; port 0 = A, 1 = B
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [3:0]  be    [2][2];
  logic [31:0] wdata [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata   [2];
  logic        busy    [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  dmem_arbiter #(.ARB_MODE(0), .AW(32)) u_fix (
    .clk(clk), .rst(rst),
    .a_req(req[0][0]), .a_we(we[0][0]), .a_addr(addr[0][0]), .a_be(be[0][0]),
    .a_wdata(wdata[0][0]), .a_ack(ack[0][0]),
    .b_req(req[0][1]), .b_we(we[0][1]), .b_addr(addr[0][1]), .b_be(be[0][1]),
    .b_wdata(wdata[0][1]), .b_ack(ack[0][1]),
    .rdata(rdata[0]), .busy(busy[0]), .m_we(m_we[0]), .m_addr(m_addr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0])
  );

  dmem_arbiter #(.ARB_MODE(1), .AW(32)) u_rr (
    .clk(clk), .rst(rst),
    .a_req(req[1][0]), .a_we(we[1][0]), .a_addr(addr[1][0]), .a_be(be[1][0]),
    .a_wdata(wdata[1][0]), .a_ack(ack[1][0]),
    .b_req(req[1][1]), .b_we(we[1][1]), .b_addr(addr[1][1]), .b_be(be[1][1]),
    .b_wdata(wdata[1][1]), .b_ack(ack[1][1]),
    .rdata(rdata[1]), .busy(busy[1]), .m_we(m_we[1]), .m_addr(m_addr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1])
  );

  // memory devices: 256 words each, loaded on the first clock edge
  logic [31:0] mem [2][256];
  bit          mem_loaded = 1'b0;
  int          pulses [2] = '{0, 0};
  logic [31:0] last_wdata [2];

  function automatic logic [31:0] init_word(input int inst, input int idx);
    logic [7:0] b;
    if (idx == 4) return 32'hDEADBEEF;
    if (idx == 8) return 32'h11223344;
    b = 8'(idx);
    return {b, 8'(inst * 3 + 1), ~b, b ^ 8'h5A};
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 256; j++) mem[i][j] <= init_word(i, j);
      mem_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_we[i]) begin
          mem[i][m_addr[i][9:2]] <= m_wdata[i];
          pulses[i]              <= pulses[i] + 1;
          last_wdata[i]          <= m_wdata[i];
        end
      end
    end
  end

  assign m_rdata[0] = mem[0][m_addr[0][9:2]];
  assign m_rdata[1] = mem[1][m_addr[1][9:2]];

  // reference model state
  logic [31:0] ref_mem   [2][256];
  logic [31:0] ref_rdata [2];
  int          ref_ptr   [2];
  int          order     [2][$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] bm);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (bm[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // drive one request from a negedge; lat = cycle number of the ack (request cycle = 1)
  task automatic txn(input int inst, input int port, input logic w, input logic [31:0] ad,
                     input logic [3:0] bm, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd);
    time t0;
    t0 = $time;
    req[inst][port]   = 1'b1;
    we[inst][port]    = w;
    addr[inst][port]  = ad;
    be[inst][port]    = bm;
    wdata[inst][port] = wd;
    lat = -1;
    rd  = 32'h0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack[inst][port]) begin
        lat = int'(($time - t0) / 10) + 1;
        rd  = rdata[inst];
        break;
      end
    end
    req[inst][port] = 1'b0;
    if (lat < 0) check($sformatf("timeout_i%0d_p%0d", inst, port), 32'd0, 32'd1);
    else order[inst].push_back(port);
  endtask

  task automatic single(input int inst, input int port, input logic w, input logic [31:0] ad,
                        input logic [3:0] bm, input logic [31:0] wd, input string tag);
    int lat, explat, p0, idx;
    logic [31:0] rd;
    idx    = int'(ad[9:2]);
    p0     = pulses[inst];
    explat = !w ? 3 : (bm == 4'h0) ? 2 : (bm == 4'hF) ? 3 : 4;
    txn(inst, port, w, ad, bm, wd, lat, rd);
    check({tag, "_lat"}, 32'(lat), 32'(explat));
    if (!w) begin
      ref_rdata[inst] = ref_mem[inst][idx];
    end else if (bm != 4'h0) begin
      ref_mem[inst][idx] = merge(ref_mem[inst][idx], wd, bm);
      check({tag, "_mwdata"}, last_wdata[inst], ref_mem[inst][idx]);
    end
    ref_ptr[inst] = 1 - port;
    check({tag, "_rdata"}, rd, ref_rdata[inst]);
    check({tag, "_pulses"}, 32'(pulses[inst] - p0), (w && bm != 4'h0) ? 32'd1 : 32'd0);
    check({tag, "_mem"}, mem[inst][idx], ref_mem[inst][idx]);
    @(negedge clk);
    check({tag, "_idle"}, 32'(busy[inst]), 32'd0);
  endtask

  // both ports issue nper back-to-back reads with req held high throughout
  task automatic conflict(input int inst, input int nper, input string tag, output int lat_b0);
    int exp_order[$];
    int rem[2];
    int fav;
    order[inst].delete();
    rem = '{nper, nper};
    fav = ref_ptr[inst];
    while (rem[0] > 0 || rem[1] > 0) begin
      int w;
      if (rem[0] > 0 && rem[1] > 0) w = (inst == 1) ? fav : 0;
      else                          w = (rem[0] > 0) ? 0 : 1;
      exp_order.push_back(w);
      rem[w]--;
      fav = 1 - w;
    end
    ref_ptr[inst] = fav;
    lat_b0 = -1;
    fork
      begin
        for (int k = 0; k < nper; k++) begin
          int l;
          logic [31:0] rd, ad;
          ad = 32'($urandom_range(0, 63) << 2);
          txn(inst, 0, 1'b0, ad, 4'h0, 32'h0, l, rd);
          check($sformatf("%s_rdA%0d", tag, k), rd, ref_mem[inst][ad[9:2]]);
        end
      end
      begin
        for (int k = 0; k < nper; k++) begin
          int l;
          logic [31:0] rd, ad;
          ad = 32'($urandom_range(64, 127) << 2);
          txn(inst, 1, 1'b0, ad, 4'h0, 32'h0, l, rd);
          if (k == 0) lat_b0 = l;
          check($sformatf("%s_rdB%0d", tag, k), rd, ref_mem[inst][ad[9:2]]);
        end
      end
    join
    ref_rdata[inst] = rdata[inst];
    check({tag, "_count"}, 32'(order[inst].size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < order[inst].size(); k++)
      check($sformatf("%s_order%0d", tag, k), 32'(order[inst][k]), 32'(exp_order[k]));
    @(negedge clk);
  endtask

  initial begin
    int lat_b0, p0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = 32'h0;
        be[i][p] = 4'h0;  wdata[i][p] = 32'h0;
      end
      for (int j = 0; j < 256; j++) ref_mem[i][j] = init_word(i, j);
      ref_rdata[i] = 32'h0;
      ref_ptr[i]   = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_a_ack%0d", i), 32'(ack[i][0]), 32'd0);
      check($sformatf("rst_b_ack%0d", i), 32'(ack[i][1]), 32'd0);
      check($sformatf("rst_m_we%0d", i), 32'(m_we[i]), 32'd0);
      check($sformatf("rst_m_addr%0d", i), m_addr[i], 32'd0);
      check($sformatf("rst_m_wdata%0d", i), m_wdata[i], 32'd0);
      check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    single(0, 0, 1'b0, 32'h10, 4'h0, 32'h0, "rd_deadbeef");
    check("rd_deadbeef_val", rdata[0], 32'hDEADBEEF);
    single(0, 1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "partial");
    check("partial_word", last_wdata[0], 32'h11BB33DD);
    single(0, 0, 1'b1, 32'h30, 4'h0, 32'hCAFEF00D, "zero_be");
    single(1, 1, 1'b1, 32'h34, 4'hF, 32'h0BADC0DE, "full_wr");

    conflict(0, 1, "fix_conf", lat_b0);
    check("fix_conf_b_lat", 32'(lat_b0), 32'd6);

    // round-robin instance has only served B once, so the pointer favours A
    conflict(1, 2, "rr_conf", lat_b0);

    // randomized single-port traffic on both instances
    for (int n = 0; n < 40; n++) begin
      int inst, port, sel;
      logic w;
      logic [31:0] ad;
      logic [3:0] bm;
      inst = n % 2;
      port = int'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      ad   = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      sel  = int'($urandom_range(0, 5));
      bm   = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
      single(inst, port, w, ad, bm, $urandom, $sformatf("rnd%0d", n));
    end
    conflict(1, 3, "rr_conf2", lat_b0);

    // reset while the write strobe is high
    p0 = pulses[0];
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 32'h40;
    be[0][0] = 4'hF;  wdata[0][0] = $urandom;
    @(negedge clk);
    check("rstwr_mwe_before", 32'(m_we[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstwr_mwe_async", 32'(m_we[0]), 32'd0);
    check("rstwr_ack", 32'(ack[0][0]), 32'd0);
    check("rstwr_busy", 32'(busy[0]), 32'd0);
    req[0][0] = 1'b0; we[0][0] = 1'b0;
    @(negedge clk);
    check("rstwr_ack_hold", 32'(ack[0][0]), 32'd0);
    rst = 1'b1;
    ref_ptr   = '{0, 0};
    ref_rdata = '{32'h0, 32'h0};
    @(negedge clk);
    check("rstwr_idle", 32'(busy[0]), 32'd0);
    check("rstwr_mwe_after", 32'(m_we[0]), 32'd0);
    check("rstwr_pulses", 32'(pulses[0] - p0), 32'd0);
    check("rstwr_mem", mem[0][16], ref_mem[0][16]);
    single(0, 1, 1'b0, 32'h40, 4'h0, 32'h0, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
